// File: rtl/als_pkg.sv
// Shared definitions for the ambient-light sampling path: FSM state encoding,
// default timing constants and the sensor data width.
package als_pkg;
    localparam int DATA_W            = 8;
    localparam int SAMPLE_PERIOD_DEF = 1_000_000;
    localparam int AVG_LOG2_DEF      = 3;
    localparam int TIMEOUT_DEF       = 2000;

    typedef logic [2:0] als_state_t;

    localparam als_state_t S_IDLE   = 3'd0;
    localparam als_state_t S_WAIT   = 3'd1;
    localparam als_state_t S_START  = 3'd2;
    localparam als_state_t S_READ   = 3'd3;
    localparam als_state_t S_UPDATE = 3'd4;
endpackage

// File: rtl/als_avg_window.sv
// Sliding-window average over the last 2^AVG_LOG2 samples: circular buffer,
// running sum, write pointer and a saturating fill counter that drives avg_valid.
module als_avg_window
    import als_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] average,
    output logic              avg_valid
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [DATA_W-1:0]   win_q [DEPTH];
    logic [DATA_W-1:0]   win_d [DEPTH];
    logic [AVG_LOG2-1:0] wptr_q, wptr_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    // The slot being overwritten leaves the sum as the new sample enters, so the
    // sum always equals the buffer contents and cannot overflow SUM_W bits.
    always_comb begin
        win_d  = win_q;
        wptr_d = wptr_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        if (push) begin
            sum_d         = sum_q - SUM_W'(win_q[wptr_q]) + SUM_W'(din);
            win_d[wptr_q] = din;
            wptr_d        = wptr_q + AVG_LOG2'(1);
            if (!fill_q[AVG_LOG2]) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            wptr_q <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            wptr_q <= wptr_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    assign average   = sum_q[SUM_W-1:AVG_LOG2];
    assign avg_valid = fill_q[AVG_LOG2];
endmodule

// File: rtl/als_sample_scheduler.sv
// Periodic ambient-light sample scheduler: issues reads, collects results, flags errors.
// Define ALS_MINMAX_EN to enable running min/max tracking of the sample stream.
module als_sample_scheduler
    import als_pkg::*;
#(
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF
) (
    input  logic              clk_10Mhz,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_err,
    output logic              rd_start,
    input  logic              rd_done,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] average,
    output logic              avg_valid,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    als_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              pending_q, pending_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              tick, push, sample_load, tmo_fire;

    assign tick = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_10Mhz or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_WAIT;
            S_WAIT:   if (!enable) state_d = S_IDLE;
                      else if (pending_q) state_d = S_START;
            S_START:  state_d = S_READ;
            S_READ:   if (rd_done) state_d = S_UPDATE;
                      else if (tmo_q == TMO_LAST) state_d = enable ? S_WAIT : S_IDLE;
            S_UPDATE: state_d = enable ? S_WAIT : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A done pulse on the terminal timeout count wins over the error.
    always_comb begin
        rd_start    = (state_q == S_START);
        push        = (state_q == S_UPDATE);
        sample_load = (state_q == S_READ) && rd_done;
        tmo_fire    = (state_q == S_READ) && !rd_done && (tmo_q == TMO_LAST);
    end

    always_comb begin
        cnt_d         = (state_q == S_IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
        tmo_d         = tmo_q;
        pending_d     = pending_q;
        timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
        overrun_err_d = clear_err ? 1'b0 : overrun_err_q;
        sample_d      = sample_load ? rd_data : sample_q;
        if (state_q == S_START) begin
            tmo_d     = '0;
            pending_d = 1'b0;
        end else if (state_q == S_READ) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (tick) begin
            if (pending_q && state_q != S_START) overrun_err_d = 1'b1;
            else                                 pending_d     = 1'b1;
        end
        if (state_q == S_IDLE) pending_d = 1'b0;
        if (tmo_fire) timeout_err_d = 1'b1;
    end

    always_ff @(posedge clk_10Mhz or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            tmo_q         <= '0;
            pending_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            sample_q      <= '0;
        end else begin
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            pending_q     <= pending_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            sample_q      <= sample_d;
        end
    end

    assign sample      = sample_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

    als_avg_window #(.AVG_LOG2(AVG_LOG2)) u_window (
        .clk       (clk_10Mhz),
        .rst       (reset),
        .push      (push),
        .din       (sample_q),
        .average   (average),
        .avg_valid (avg_valid)
    );

`ifdef ALS_MINMAX_EN
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = clear_err ? '1 : min_q;
        max_d = clear_err ? '0 : max_q;
        if (push && sample_q < min_d) min_d = sample_q;
        if (push && sample_q > max_d) max_d = sample_q;
    end

    always_ff @(posedge clk_10Mhz or posedge reset) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
`else
    assign min_val = '1;
    assign max_val = '0;
`endif
endmodule

// File: tb/tb_als_sample_scheduler.sv
// Randomized self-checking bench for als_sample_scheduler against a queue-based
// reference model; a second instance with a long timeout exercises overrun.
module tb_als_sample_scheduler;
    localparam int P      = 100;
    localparam int L      = 2;
    localparam int T      = 20;
    localparam int T_OVR  = 400;
    localparam int DEPTH  = 1 << L;
    localparam int RD_DLY = 5;
    localparam int LATE   = 150;
`ifdef ALS_MINMAX_EN
    localparam int MIN5 = 'h10;
    localparam int MAX5 = 'h50;
`else
    localparam int MIN5 = 'hFF;
    localparam int MAX5 = 'h00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, clear_err, rd_done;
    logic [7:0] rd_data;
    logic       rd_start, avg_valid, timeout_err, overrun_err;
    logic [7:0] sample, average, min_val, max_val;

    logic       o_enable, o_rd_done;
    logic       o_rd_start, o_avg_valid, o_timeout_err, o_overrun_err;
    logic [7:0] o_sample, o_average, o_min_val, o_max_val;

    als_sample_scheduler #(.SAMPLE_PERIOD(P), .AVG_LOG2(L), .TIMEOUT(T)) u_dut (
        .clk_10Mhz(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .rd_start(rd_start), .rd_done(rd_done), .rd_data(rd_data),
        .sample(sample), .average(average), .avg_valid(avg_valid),
        .timeout_err(timeout_err), .overrun_err(overrun_err),
        .min_val(min_val), .max_val(max_val)
    );

    als_sample_scheduler #(.SAMPLE_PERIOD(P), .AVG_LOG2(L), .TIMEOUT(T_OVR)) u_ovr (
        .clk_10Mhz(clk), .reset(reset), .enable(o_enable), .clear_err(clear_err),
        .rd_start(o_rd_start), .rd_done(o_rd_done), .rd_data(rd_data),
        .sample(o_sample), .average(o_average), .avg_valid(o_avg_valid),
        .timeout_err(o_timeout_err), .overrun_err(o_overrun_err),
        .min_val(o_min_val), .max_val(o_max_val)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     starts   = 0;
    int     o_starts = 0;
    int     o_done   = 0;
    longint t_prev   = 0;
    longint t_last   = 0;
    int     hist[$];
    int     min_m    = 255;
    int     max_m    = 0;

    always @(negedge clk) begin
        if (rd_start === 1'b1)   starts++;
        if (o_rd_start === 1'b1) o_starts++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Window average of the newest DEPTH readings; slots never written count as zero.
    function automatic int model_avg();
        int s = 0;
        for (int i = 0; i < DEPTH && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
        return s / DEPTH;
    endfunction

    function automatic int exp_min();
`ifdef ALS_MINMAX_EN
        return min_m;
`else
        return 'hFF;
`endif
    endfunction

    function automatic int exp_max();
`ifdef ALS_MINMAX_EN
        return max_m;
`else
        return 'h00;
`endif
    endfunction

    function automatic int gap();
        return int'((t_last - t_prev) / 10);
    endfunction

    task automatic wait_start(input bit ovr, input int budget, input string tag, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((ovr ? o_rd_start : rd_start) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) check_eq({tag, "_seen"}, 32'(ovr ? o_rd_start : rd_start), 1);
        t_prev = t_last;
        t_last = $time;
    endtask

    // Called on the negedge where rd_start is first seen; rd_done lands 'delay' edges later.
    task automatic do_read(input logic [7:0] d, input int delay);
        int prev_avg;
        prev_avg = model_avg();
        @(negedge clk);
        check_eq("start_width", 32'(rd_start), 0);
        repeat (delay - 2) @(negedge clk);
        rd_done = 1'b1;
        rd_data = d;
        @(negedge clk);
        rd_done = 1'b0;
        check_eq("sample", 32'(sample), 32'(d));
        check_eq("avg_lag", 32'(average), prev_avg);
        hist.push_back(int'(d));
        if (int'(d) < min_m) min_m = int'(d);
        if (int'(d) > max_m) max_m = int'(d);
        @(negedge clk);
        check_eq("average", 32'(average), model_avg());
        check_eq("avg_valid", 32'(avg_valid), (hist.size() >= DEPTH) ? 1 : 0);
        check_eq("min_val", 32'(min_val), exp_min());
        check_eq("max_val", 32'(max_val), exp_max());
        $display("read data=%02h sample=%02h avg=%02h valid=%0d min=%02h max=%02h",
                 d, sample, average, avg_valid, min_val, max_val);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_start"}, 32'(rd_start), 0);
        check_eq({tag, "_sample"}, 32'(sample), 0);
        check_eq({tag, "_average"}, 32'(average), 0);
        check_eq({tag, "_avg_valid"}, 32'(avg_valid), 0);
        check_eq({tag, "_timeout"}, 32'(timeout_err), 0);
        check_eq({tag, "_overrun"}, 32'(overrun_err), 0);
        check_eq({tag, "_min"}, 32'(min_val), 'hFF);
        check_eq({tag, "_max"}, 32'(max_val), 'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         s0;
        logic [7:0] d;
        logic [7:0] s_before;
        logic [7:0] seq [5];
        seq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

        reset = 1'b1; enable = 1'b0; clear_err = 1'b0; rd_done = 1'b0; rd_data = 8'h00;
        o_enable = 1'b0; o_rd_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // First request: enable seen at edge e0, rd_start high after edge e0+P+1.
        @(negedge clk);
        enable = 1'b1;
        wait_start(0, P + 10, "first", n);
        check_eq("first_lat", n, P + 2);
        for (int r = 0; r < 11; r++) begin
            if (r > 0) begin
                wait_start(0, P + 10, "period", n);
                check_eq("period_gap", gap(), P);
            end
            d = (r < 5) ? seq[r] : 8'($urandom_range(0, 255));
            do_read(d, RD_DLY);
            if (r == 3) begin
                check_eq("avg4", 32'(average), 'h28);
                check_eq("valid4", 32'(avg_valid), 1);
            end
            if (r == 4) begin
                check_eq("avg5", 32'(average), 'h38);
                check_eq("min5", 32'(min_val), MIN5);
                check_eq("max5", 32'(max_val), MAX5);
            end
        end

        // Silent reader: error appears T edges after the edge that consumed rd_start.
        wait_start(0, P + 10, "tmo1", n);
        check_eq("tmo1_gap", gap(), P);
        s_before = sample;
        n = -1;
        for (int i = 1; i <= T + 10; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                n = i;
                break;
            end
        end
        check_eq("tmo_latency", n, T + 1);
        check_eq("tmo_sample", 32'(sample), 32'(s_before));
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        min_m = 255;
        max_m = 0;
        check_eq("clear_err", 32'(timeout_err), 0);
        check_eq("clear_min", 32'(min_val), 'hFF);
        check_eq("clear_max", 32'(max_val), 'h00);
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = 8'hEE;
        @(negedge clk);
        rd_done = 1'b0;
        check_eq("stray_done", 32'(sample), 32'(s_before));
        $display("timeout read: sample=%02h timeout_err cleared", sample);

        wait_start(0, P + 10, "tmo2", n);
        check_eq("tmo2_gap", gap(), P);
        repeat (T) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("set_beats_clear", 32'(timeout_err), 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("clear_again", 32'(timeout_err), 0);
        $display("timeout read with coincident clear_err: timeout_err held");

        wait_start(0, P + 10, "edge", n);
        check_eq("edge_gap", gap(), P);
        do_read(8'($urandom_range(0, 255)), T + 1);
        check_eq("done_beats_tmo", 32'(timeout_err), 0);

        // Dropping enable mid-read lets the read finish, then the scheduler parks.
        wait_start(0, P + 10, "en_drop", n);
        check_eq("en_drop_gap", gap(), P);
        enable = 1'b0;
        do_read(8'h77, RD_DLY);
        s0 = starts;
        repeat (3 * P) @(negedge clk);
        check_eq("no_start_idle", starts - s0, 0);
        check_eq("no_overrun", 32'(overrun_err), 0);

        enable = 1'b1;
        wait_start(0, P + 10, "reenable", n);
        check_eq("reenable_lat", n, P + 2);
        do_read(8'($urandom_range(0, 255)), RD_DLY);

        // Reset in the middle of a read, then a late rd_done that must be ignored.
        wait_start(0, P + 10, "rst_rd", n);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_rst");
        hist.delete();
        min_m = 255;
        max_m = 0;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = 8'h99;
        @(negedge clk);
        rd_done = 1'b0;
        @(negedge clk);
        check_eq("late_sample", 32'(sample), 0);
        check_eq("late_valid", 32'(avg_valid), 0);
        check_eq("late_avg", 32'(average), 0);
        $display("reset mid-read: sample=%02h avg_valid=%0d", sample, avg_valid);

        // Slow reader on the long-timeout instance: the tick after the second
        // request lands while the request is still outstanding.
        o_enable = 1'b1;
        wait_start(1, P + 10, "o_first", n);
        check_eq("o_first_lat", n, P + 2);
        for (int r = 0; r < 2; r++) begin
            if (r > 0) wait_start(1, P + 10, "o_next", n);
            d = 8'($urandom_range(0, 255));
            repeat (LATE - 1) @(negedge clk);
            o_rd_done = 1'b1;
            rd_data   = d;
            @(negedge clk);
            o_rd_done = 1'b0;
            o_done++;
            check_eq("o_sample", 32'(o_sample), 32'(d));
            check_eq("o_overrun", 32'(o_overrun_err), (r == 1) ? 1 : 0);
            check_eq("o_starts", o_starts, o_done);
            $display("slow read %0d data=%02h overrun=%0d starts=%0d", r, d, o_overrun_err, o_starts);
        end
        check_eq("o_timeout", 32'(o_timeout_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/als_sample_scheduler.md
# als_sample_scheduler

Periodic sampling controller for the ambient-light sensor path. Issues one read request per sample period to the serial sensor reader and collects each returned 8-bit reading. Maintains a sliding-window average and error/status flags. Sits between the sensor reader and the seven-segment display logic.

## Interface
- SAMPLE_PERIOD, 1_000_000: clk_10Mhz cycles between successive read requests (start-to-start); minimum 2·TIMEOUT.
- AVG_LOG2, 3: log2 of averaging window depth (window = 2^AVG_LOG2 samples); range 1..4.
- TIMEOUT, 2000: cycles allowed from rd_start to rd_done.
- clk_10Mhz  in  1  system clock, 10 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high = sampling runs.
- clear_err  in  1  one-cycle pulse; clears sticky error flags.
- rd_start  out  1  one-cycle pulse requesting one sensor conversion.
- rd_done  in  1  one-cycle pulse from reader; rd_data valid in same cycle.
- rd_data  in  8  sensor reading.
- sample  out  8  most recent raw reading.
- average  out  8  window average.
- avg_valid  out  1  high once window is full.
- timeout_err  out  1  sticky; reader failed to answer within TIMEOUT.
- overrun_err  out  1  sticky; period tick arrived while a request was still pending.
- min_val  out  8  smallest reading since reset (see Configuration).
- max_val  out  8  largest reading since reset (see Configuration).

## Operation
- Reset values: rd_start 0, sample 0, average 0, avg_valid 0, timeout_err 0, overrun_err 0, min_val 8'hFF, max_val 8'h00, state S_IDLE, all counters, window buffer and sum 0.
- Period counter: held at 0 in S_IDLE; otherwise counts 0..SAMPLE_PERIOD-1 and wraps. Wrap produces a tick, which sets pending.
  - Tick while pending is already set → overrun_err set; the tick is dropped.
- FSM states:
  - S_IDLE: enable=1 → S_WAIT.
  - S_WAIT: enable=0 → S_IDLE. pending=1 → S_START.
  - S_START: rd_start=1 for exactly this cycle; clear pending and timeout counter → S_READ.
  - S_READ: rd_done=1 → latch rd_data into sample → S_UPDATE. Timeout counter reaching TIMEOUT-1 → set timeout_err, no sample → S_WAIT (S_IDLE if enable=0).
  - S_UPDATE: update window → S_WAIT (S_IDLE if enable=0).
- enable dropping in S_START/S_READ does not abort the read; the transaction completes or times out, then goes to S_IDLE.
- Window:
  - Circular buffer of 2^AVG_LOG2 × 8 bits with a write pointer that wraps modulo the depth.
  - sum width 8+AVG_LOG2 bits, unsigned, never overflows. Update: sum ← sum − buf[wptr] + sample; buf[wptr] ← sample; wptr++.
  - average = sum >> AVG_LOG2 (truncating).
  - Fill counter saturates at 2^AVG_LOG2; avg_valid is set when it saturates and stays high until reset.
- rd_done outside S_READ: ignored.
- rd_done coincident with the timeout terminal count: done wins, no error.
- clear_err coincident with a new error event: the set wins.
- Leaving S_IDLE and re-entering it keeps the window contents, flags and min/max.

## Timing
- First rd_start occurs SAMPLE_PERIOD+1 cycles after the first edge with enable=1. Subsequent pulses are exactly SAMPLE_PERIOD apart while the reader answers within the period.
- rd_done at edge k → sample updated at edge k; sum/average updated at edge k+1. avg_valid rises at edge k+1.
- Timeout: timeout_err is set TIMEOUT cycles after the rd_start edge.
- Reset is asynchronous. Asserting it mid-read forces every output to its reset value immediately. A late rd_done arriving after reset is ignored.

## Configuration
- ALS_MINMAX_EN defined: min_val/max_val are updated in S_UPDATE with running minimum/maximum of sample; clear_err also restores them to 8'hFF/8'h00.
- Not defined: no tracking logic; min_val is constant 8'hFF and max_val is constant 8'h00.

## Structure
- Package als_pkg: state encoding localparams (S_IDLE, S_WAIT, S_START, S_READ, S_UPDATE, 3-bit), default SAMPLE_PERIOD/AVG_LOG2/TIMEOUT constants, sensor data width (8).
- One sub-module, als_avg_window: circular buffer, write pointer, sum, fill counter, avg_valid. It takes a one-cycle push strobe and the sample value.
- FSM, period counter, timeout counter and flags live in als_sample_scheduler.

## Test plan
Bench parameters: SAMPLE_PERIOD=100, AVG_LOG2=2, TIMEOUT=20; reader model answers 5 cycles after rd_start unless stated otherwise.
- Enable after reset → rd_start pulses at enable+101, +201, +301; each pulse is 1 cycle wide.
- Readings 0x10, 0x20, 0x30, 0x40 → avg_valid rises after the 4th with average=0x28. A 5th reading of 0x50 → average=0x38. With ALS_MINMAX_EN defined, min_val=0x10 and max_val=0x50.
- Reader silent → timeout_err=1 twenty cycles after rd_start; the next rd_start is still 100 cycles after the previous one; sample is unchanged. clear_err → timeout_err=0.
- Reader answers 150 cycles late with TIMEOUT raised to 400 → overrun_err=1 at the second tick; rd_start count matches the number of completed reads.
- enable=0 during S_READ, rd_done=0x77 arrives → sample=0x77, window updated, FSM reaches S_IDLE, no further rd_start.
- reset asserted during S_READ → all outputs at reset values within the same cycle; a subsequent rd_done is ignored; avg_valid=0.
